// File: rtl/operand_mux.sv
// operand_mux: 4:1 operand selector for the expression-solver datapath.
// Offers the selected operand combinationally for same-cycle consumers and
// as a one-cycle registered copy tagged with a valid flag and the select
// code that produced it. Data passes through bit-exact; signedness is only
// carried for the benefit of downstream arithmetic.
module operand_mux #(
    parameter int WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              sel_i,
    input  logic                    in_valid_i,
    input  logic signed [WIDTH-1:0] a_i,
    input  logic signed [WIDTH-1:0] b_i,
    input  logic signed [WIDTH-1:0] c_i,
    input  logic signed [WIDTH-1:0] d_i,
    output logic signed [WIDTH-1:0] out_comb_o,
    output logic signed [WIDTH-1:0] out_o,
    output logic                    out_valid_o,
    output logic [1:0]              out_sel_o
);

    logic signed [WIDTH-1:0] out_q, out_d;
    logic                    out_valid_q, out_valid_d;
    logic [1:0]              out_sel_q, out_sel_d;

    // Full decode of all four select codes; no code yields an unknown output.
    always_comb begin
        out_comb_o = a_i;
        case (sel_i)
            2'b00: out_comb_o = a_i;
            2'b01: out_comb_o = b_i;
            2'b10: out_comb_o = c_i;
            2'b11: out_comb_o = d_i;
        endcase
    end

    // Capture on a valid sample; otherwise hold data/select and drop valid.
    always_comb begin
        out_d       = out_q;
        out_sel_d   = out_sel_q;
        out_valid_d = 1'b0;
        if (in_valid_i) begin
            out_d       = out_comb_o;
            out_sel_d   = sel_i;
            out_valid_d = 1'b1;
        end
    end

    // Output registers; asynchronous reset flushes any in-flight value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            out_sel_q   <= 2'b00;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            out_sel_q   <= out_sel_d;
        end
    end

    assign out_o       = out_q;
    assign out_valid_o = out_valid_q;
    assign out_sel_o   = out_sel_q;

endmodule

// File: tb/tb_operand_mux.sv
// Self-checking bench for operand_mux: inputs change on the falling edge,
// outputs are sampled 1 time unit after the rising edge.
module tb_operand_mux;

    localparam int WIDTH = 16;
    localparam int HALF  = 5;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [1:0]       sel;
    } exp_t;

    logic                    clk;
    logic                    rst_n;
    logic [1:0]              sel_i;
    logic                    in_valid_i;
    logic signed [WIDTH-1:0] a_i, b_i, c_i, d_i;
    logic signed [WIDTH-1:0] out_comb_o;
    logic signed [WIDTH-1:0] out_o;
    logic                    out_valid_o;
    logic [1:0]              out_sel_o;

    int   vectors;
    int   miscompares;
    exp_t sb_q[$];
    exp_t e;

    logic [1:0]       seq_sel[4];
    logic [WIDTH-1:0] seq_exp[4];

    operand_mux #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sel_i       (sel_i),
        .in_valid_i  (in_valid_i),
        .a_i         (a_i),
        .b_i         (b_i),
        .c_i         (c_i),
        .d_i         (d_i),
        .out_comb_o  (out_comb_o),
        .out_o       (out_o),
        .out_valid_o (out_valid_o),
        .out_sel_o   (out_sel_o)
    );

    initial clk = 1'b0;
    always #HALF clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, limit 100000");
        $fatal(1, "timeout");
    end

    task automatic pop_expected();
        if (sb_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL scoreboard_underflow: queue empty, want entry");
            e = '0;
        end else begin
            e = sb_q.pop_front();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sel_i = 2'b00; in_valid_i = 1'b0;
        a_i = 16'h1111; b_i = 16'h2222; c_i = 16'h3333; d_i = 16'h4444;
        #2;
        vectors++;
        if ({out_o, out_valid_o, out_sel_o} !== {16'h0000, 1'b0, 2'b00}) begin
            miscompares++;
            $display("FAIL reset_async: got out=%h v=%b sel=%b, want 0000/0/00", out_o, out_valid_o, out_sel_o);
        end
        in_valid_i = 1'b1; sel_i = 2'b11;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({out_o, out_valid_o, out_sel_o} !== {16'h0000, 1'b0, 2'b00}) begin
            miscompares++;
            $display("FAIL reset_held: got out=%h v=%b sel=%b, want 0000/0/00", out_o, out_valid_o, out_sel_o);
        end
        @(negedge clk);
        rst_n = 1'b1; in_valid_i = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if ({out_o, out_valid_o, out_sel_o} !== {16'h0000, 1'b0, 2'b00}) begin
            miscompares++;
            $display("FAIL reset_release_idle: got out=%h v=%b sel=%b, want 0000/0/00", out_o, out_valid_o, out_sel_o);
        end
    endtask

    task automatic test_comb_decode();
        @(negedge clk);
        a_i = 16'hFFFF; b_i = 16'hDFFF; c_i = 16'hBFFF; d_i = 16'h9FFF;
        in_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sel_i = seq_sel[i];
            #1;
            vectors++;
            if (out_comb_o !== seq_exp[i]) begin
                miscompares++;
                $display("FAIL comb_decode[%0d]: got %h (%0d), want %h", i, out_comb_o, out_comb_o, seq_exp[i]);
            end
        end
    endtask

    task automatic test_latency();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            sel_i = seq_sel[i]; in_valid_i = 1'b1;
            sb_q.push_back('{data: seq_exp[i], sel: seq_sel[i]});
            @(posedge clk); #1;
            pop_expected();
            vectors++;
            if ({out_o, out_sel_o, out_valid_o} !== {e.data, e.sel, 1'b1}) begin
                miscompares++;
                $display("FAIL latency[%0d]: got out=%h sel=%b v=%b, want %h/%b/1", i, out_o, out_sel_o, out_valid_o, e.data, e.sel);
            end
        end
        @(negedge clk);
        in_valid_i = 1'b0;
    endtask

    task automatic test_hold();
        @(negedge clk);
        sel_i = 2'b10; in_valid_i = 1'b1;
        sb_q.push_back('{data: 16'hBFFF, sel: 2'b10});
        @(posedge clk); #1;
        pop_expected();
        vectors++;
        if ({out_o, out_sel_o, out_valid_o} !== {e.data, e.sel, 1'b1}) begin
            miscompares++;
            $display("FAIL hold_capture: got out=%h sel=%b v=%b, want %h/%b/1", out_o, out_sel_o, out_valid_o, e.data, e.sel);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid_i = 1'b0;
            sel_i = seq_sel[i];
            #1;
            vectors++;
            if (out_comb_o !== seq_exp[i]) begin
                miscompares++;
                $display("FAIL hold_comb[%0d]: got %h, want %h", i, out_comb_o, seq_exp[i]);
            end
            @(posedge clk); #1;
            vectors++;
            if ({out_o, out_sel_o, out_valid_o} !== {16'hBFFF, 2'b10, 1'b0}) begin
                miscompares++;
                $display("FAIL hold[%0d]: got out=%h sel=%b v=%b, want bfff/10/0", i, out_o, out_sel_o, out_valid_o);
            end
        end
    endtask

    task automatic test_repeat_sel();
        @(negedge clk);
        sel_i = 2'b01; in_valid_i = 1'b1; b_i = 16'hDFFF;
        sb_q.push_back('{data: 16'hDFFF, sel: 2'b01});
        @(posedge clk); #1;
        pop_expected();
        vectors++;
        if ({out_o, out_sel_o, out_valid_o} !== {e.data, e.sel, 1'b1}) begin
            miscompares++;
            $display("FAIL repeat_first: got out=%h sel=%b v=%b, want %h/%b/1", out_o, out_sel_o, out_valid_o, e.data, e.sel);
        end
        @(negedge clk);
        b_i = 16'h1234;
        sb_q.push_back('{data: 16'h1234, sel: 2'b01});
        @(posedge clk); #1;
        pop_expected();
        vectors++;
        if ({out_o, out_sel_o, out_valid_o} !== {e.data, e.sel, 1'b1}) begin
            miscompares++;
            $display("FAIL repeat_second: got out=%h sel=%b v=%b, want %h/%b/1", out_o, out_sel_o, out_valid_o, e.data, e.sel);
        end
        @(negedge clk);
        in_valid_i = 1'b0; b_i = 16'hDFFF;
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        sel_i = 2'b11; in_valid_i = 1'b1;
        sb_q.push_back('{data: 16'h9FFF, sel: 2'b11});
        @(posedge clk); #1;
        pop_expected();
        vectors++;
        if ({out_o, out_sel_o, out_valid_o} !== {e.data, e.sel, 1'b1}) begin
            miscompares++;
            $display("FAIL areset_pre: got out=%h sel=%b v=%b, want %h/%b/1", out_o, out_sel_o, out_valid_o, e.data, e.sel);
        end
        #1;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({out_o, out_sel_o, out_valid_o} !== {16'h0000, 2'b00, 1'b0}) begin
            miscompares++;
            $display("FAIL areset_immediate: got out=%h sel=%b v=%b, want 0000/00/0", out_o, out_sel_o, out_valid_o);
        end
        @(negedge clk);
        sel_i = 2'b10;
        @(posedge clk); #1;
        vectors++;
        if ({out_o, out_sel_o, out_valid_o} !== {16'h0000, 2'b00, 1'b0}) begin
            miscompares++;
            $display("FAIL areset_flush: got out=%h sel=%b v=%b, want 0000/00/0", out_o, out_sel_o, out_valid_o);
        end
        @(negedge clk);
        rst_n = 1'b1; sel_i = 2'b00; in_valid_i = 1'b1;
        sb_q.push_back('{data: 16'hFFFF, sel: 2'b00});
        @(posedge clk); #1;
        pop_expected();
        vectors++;
        if ({out_o, out_sel_o, out_valid_o} !== {e.data, e.sel, 1'b1}) begin
            miscompares++;
            $display("FAIL areset_recover: got out=%h sel=%b v=%b, want %h/%b/1", out_o, out_sel_o, out_valid_o, e.data, e.sel);
        end
    endtask

    task automatic test_collision();
        @(negedge clk);
        sel_i = 2'b11; in_valid_i = 1'b1;
        sb_q.push_back('{data: 16'h9FFF, sel: 2'b11});
        @(posedge clk); #1;
        pop_expected();
        vectors++;
        if ({out_o, out_sel_o, out_valid_o} !== {e.data, e.sel, 1'b1}) begin
            miscompares++;
            $display("FAIL collide_pre: got out=%h sel=%b v=%b, want %h/%b/1", out_o, out_sel_o, out_valid_o, e.data, e.sel);
        end
        @(negedge clk);
        sel_i = 2'b10; in_valid_i = 1'b1;
        #HALF;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({out_o, out_sel_o, out_valid_o} !== {16'h0000, 2'b00, 1'b0}) begin
            miscompares++;
            $display("FAIL collide: got out=%h sel=%b v=%b, want 0000/00/0", out_o, out_sel_o, out_valid_o);
        end
        @(negedge clk);
        rst_n = 1'b1; in_valid_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] last_out;
        logic [1:0]       last_sel;
        logic             drove_valid;
        logic [WIDTH-1:0] pick;
        last_out = 16'h0000;
        last_sel = 2'b00;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            a_i = WIDTH'($urandom); b_i = WIDTH'($urandom);
            c_i = WIDTH'($urandom); d_i = WIDTH'($urandom);
            sel_i = 2'($urandom_range(3, 0));
            drove_valid = ($urandom_range(3, 0) != 0);
            in_valid_i = drove_valid;
            unique case (sel_i)
                2'b00: pick = a_i;
                2'b01: pick = b_i;
                2'b10: pick = c_i;
                default: pick = d_i;
            endcase
            #1;
            vectors++;
            if (out_comb_o !== pick) begin
                miscompares++;
                $display("FAIL b2b_comb[%0d]: got %h, want %h", i, out_comb_o, pick);
            end
            if (drove_valid) sb_q.push_back('{data: pick, sel: sel_i});
            @(posedge clk); #1;
            if (drove_valid) begin
                pop_expected();
                last_out = e.data;
                last_sel = e.sel;
            end
            vectors++;
            if ({out_o, out_sel_o, out_valid_o} !== {last_out, last_sel, drove_valid}) begin
                miscompares++;
                $display("FAIL b2b[%0d]: got out=%h sel=%b v=%b, want %h/%b/%b", i, out_o, out_sel_o, out_valid_o, last_out, last_sel, drove_valid);
            end
        end
        @(negedge clk);
        in_valid_i = 1'b0;
        vectors++;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d left, want 0", sb_q.size());
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        seq_sel[0] = 2'b00; seq_exp[0] = 16'hFFFF;
        seq_sel[1] = 2'b11; seq_exp[1] = 16'h9FFF;
        seq_sel[2] = 2'b10; seq_exp[2] = 16'hBFFF;
        seq_sel[3] = 2'b01; seq_exp[3] = 16'hDFFF;
        test_reset();
        test_comb_decode();
        test_latency();
        test_hold();
        test_repeat_sel();
        test_async_reset();
        test_collision();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
